// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-line and status bundle between the intersection controller side
// (master: drives lamps and the supervisor clear, reads monitor status)
// and the conflict monitor (slave: observes lamps, reports faults).
//   ns_red/ns_yellow/ns_green, ew_red/ew_yellow/ew_green : lamp lines
//   fault_clr    : supervisor clear request, level
//   fault        : latched fault flag
//   fault_code   : first fault cause (0 none,1 conflict,2 lamp,3 sequence,
//                  4 short yellow,5 short green)
//   flash_red    : flashing-red override request
//   ns_phase_cnt : completed legal NS R->G entries, wraps
`timescale 1ns/1ps
interface traffic_conflict_monitor_if;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;
  logic [7:0] ns_phase_cnt;

  modport master (
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
    input  fault, fault_code, flash_red, ns_phase_cnt
  );

  modport slave (
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
    output fault, fault_code, flash_red, ns_phase_cnt
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for the six intersection lamp lines.
// Registers the lamps and the clear request, decodes each approach,
// checks conflict / invalid pattern / sequencing / dwell, latches the
// first fault with its cause and requests flashing red until a
// supervised clear with both approaches showing red.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : traffic_conflict_monitor_if.slave (lamps, fault_clr in;
//          fault, fault_code, flash_red, ns_phase_cnt out)
`timescale 1ns/1ps
module traffic_conflict_monitor #(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned LAMP_TOL   = 3,
  parameter int unsigned FLASH_HALF = 2,
  parameter int unsigned CNT_W      = 6
) (
  input logic                      clk,
  input logic                      rst,
  traffic_conflict_monitor_if.slave bus
);

  localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_CONFLICT  = 3'd1;
  localparam logic [2:0] CODE_LAMP      = 3'd2;
  localparam logic [2:0] CODE_SEQ       = 3'd3;
  localparam logic [2:0] CODE_SHORT_YEL = 3'd4;
  localparam logic [2:0] CODE_SHORT_GRN = 3'd5;

  typedef enum logic [1:0] {LAMP_RED, LAMP_YEL, LAMP_GRN, LAMP_BAD} lamp_e;
  typedef enum logic {MON_OK, MON_FAULT} mon_state_e;

  // Lamp vectors are packed {red, yellow, green}.
  function automatic lamp_e decode(input logic [2:0] l);
    lamp_e d;
    case (l)
      3'b100:  d = LAMP_RED;
      3'b010:  d = LAMP_YEL;
      3'b001:  d = LAMP_GRN;
      default: d = LAMP_BAD;
    endcase
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] trans_code(input lamp_e prev, input lamp_e cur,
                                            input logic [CNT_W-1:0] dwell);
    logic [2:0] code;
    code = CODE_NONE;
    if (cur != LAMP_BAD && cur != prev) begin
      case (prev)
        LAMP_RED: if (cur != LAMP_GRN) code = CODE_SEQ;
        LAMP_GRN: begin
          if (cur != LAMP_YEL)                    code = CODE_SEQ;
          else if (dwell < CNT_W'(MIN_GREEN))     code = CODE_SHORT_GRN;
        end
        LAMP_YEL: begin
          if (cur != LAMP_RED)                    code = CODE_SEQ;
          else if (dwell < CNT_W'(MIN_YELLOW))    code = CODE_SHORT_YEL;
        end
        default: code = CODE_NONE;
      endcase
    end
    return code;
  endfunction

  // Input stage
  logic [2:0] ns_lamps_q, ew_lamps_q;
  logic       clr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_lamps_q <= '0;
      ew_lamps_q <= '0;
      clr_q      <= 1'b0;
    end else begin
      ns_lamps_q <= {bus.ns_red, bus.ns_yellow, bus.ns_green};
      ew_lamps_q <= {bus.ew_red, bus.ew_yellow, bus.ew_green};
      clr_q      <= bus.fault_clr;
    end
  end

  // Per-approach tracking state
  lamp_e            ns_prev, ew_prev;
  logic [CNT_W-1:0] ns_dwell, ew_dwell;
  logic [CNT_W-1:0] ns_bad, ew_bad;
  logic [7:0]       phase_q;
  logic [2:0]       code_q;
  logic             flash_q;
  logic [FLASH_W-1:0] flash_cnt;

  mon_state_e state, state_nxt;

  lamp_e            ns_cur, ew_cur;
  logic [CNT_W-1:0] ns_bad_nxt, ew_bad_nxt;
  logic [2:0]       ns_tc, ew_tc, seq_code, det_code;
  logic             conflict_det, lamp_det, clr_ok;
  logic             fault_set, fault_clear, track_en;

  always_comb begin
    ns_cur     = decode(ns_lamps_q);
    ew_cur     = decode(ew_lamps_q);
    ns_bad_nxt = (ns_cur == LAMP_BAD) ? sat_inc(ns_bad) : '0;
    ew_bad_nxt = (ew_cur == LAMP_BAD) ? sat_inc(ew_bad) : '0;
    lamp_det   = (ns_cur == LAMP_BAD && ns_bad_nxt >= CNT_W'(LAMP_TOL)) ||
                 (ew_cur == LAMP_BAD && ew_bad_nxt >= CNT_W'(LAMP_TOL));
    conflict_det = (ns_cur inside {LAMP_YEL, LAMP_GRN}) &&
                   (ew_cur inside {LAMP_YEL, LAMP_GRN});
    ns_tc = trans_code(ns_prev, ns_cur, ns_dwell);
    ew_tc = trans_code(ew_prev, ew_cur, ew_dwell);
    // Lowest non-zero sequence/dwell code of the two approaches.
    seq_code = ns_tc;
    if (ew_tc != CODE_NONE && (ns_tc == CODE_NONE || ew_tc < ns_tc))
      seq_code = ew_tc;
    clr_ok = clr_q && ns_cur == LAMP_RED && ew_cur == LAMP_RED;
  end

  // Sequence checks compare against tracking frozen at fault time; in a
  // clear cycle that history is stale (e.g. frozen GRN now showing RED)
  // and would re-fault forever, so only conflict/lamp checks count there.
  always_comb begin
    det_code = CODE_NONE;
    if (conflict_det)          det_code = CODE_CONFLICT;
    else if (lamp_det)         det_code = CODE_LAMP;
    else if (state == MON_OK)  det_code = seq_code;
  end

  // Fault FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MON_OK;
    else     state <= state_nxt;
  end

  // Fault FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      MON_OK:    if (det_code != CODE_NONE) state_nxt = MON_FAULT;
      MON_FAULT: if (clr_ok && det_code == CODE_NONE) state_nxt = MON_OK;
      default:   state_nxt = MON_OK;
    endcase
  end

  // Fault FSM: outputs and control strobes
  always_comb begin
    bus.fault   = (state == MON_FAULT);
    track_en    = (state == MON_OK);
    fault_set   = (det_code != CODE_NONE) && (state == MON_OK || clr_ok);
    fault_clear = (state == MON_FAULT) && clr_ok && det_code == CODE_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q    <= CODE_NONE;
      flash_q   <= 1'b0;
      flash_cnt <= '0;
    end else if (fault_set) begin
      code_q    <= det_code;
      flash_q   <= 1'b1;
      flash_cnt <= '0;
    end else if (state == MON_FAULT && !fault_clear) begin
      if (flash_cnt == FLASH_W'(FLASH_HALF - 1)) begin
        flash_q   <= ~flash_q;
        flash_cnt <= '0;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end else begin
      code_q    <= CODE_NONE;
      flash_q   <= 1'b0;
      flash_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_prev  <= LAMP_RED;
      ew_prev  <= LAMP_RED;
      ns_dwell <= '0;
      ew_dwell <= '0;
      ns_bad   <= '0;
      ew_bad   <= '0;
      phase_q  <= '0;
    end else begin
      ns_bad <= ns_bad_nxt;
      ew_bad <= ew_bad_nxt;
      if (fault_clear) begin
        ns_prev  <= LAMP_RED;
        ew_prev  <= LAMP_RED;
        ns_dwell <= '0;
        ew_dwell <= '0;
      end else if (track_en) begin
        if (ns_cur != LAMP_BAD) begin
          if (ns_cur == ns_prev) begin
            ns_dwell <= sat_inc(ns_dwell);
          end else begin
            ns_prev  <= ns_cur;
            ns_dwell <= CNT_W'(1);
          end
        end
        if (ew_cur != LAMP_BAD) begin
          if (ew_cur == ew_prev) begin
            ew_dwell <= sat_inc(ew_dwell);
          end else begin
            ew_prev  <= ew_cur;
            ew_dwell <= CNT_W'(1);
          end
        end
        if (ns_prev == LAMP_RED && ns_cur == LAMP_GRN)
          phase_q <= phase_q + 8'd1;
      end
    end
  end

  assign bus.fault_code   = code_q;
  assign bus.flash_red    = flash_q;
  assign bus.ns_phase_cnt = phase_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
`timescale 1ns/1ps
module tb_traffic_conflict_monitor;

  logic clk = 1'b0;
  logic rst;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .MIN_GREEN (8),
    .MIN_YELLOW(4),
    .LAMP_TOL  (3),
    .FLASH_HALF(2),
    .CNT_W     (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct {
    int unsigned cyc;
    logic        f;
    logic [2:0]  code;
    int          flash;   // -1: not checked
    int          phase;   // -1: not checked
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_lamps(input logic [2:0] ns, input logic [2:0] ew);
    bus.ns_red    = ns[2];
    bus.ns_yellow = ns[1];
    bus.ns_green  = ns[0];
    bus.ew_red    = ew[2];
    bus.ew_yellow = ew[1];
    bus.ew_green  = ew[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] ns, input logic [2:0] ew, input int n);
    set_lamps(ns, ew);
    repeat (n) tick();
  endtask

  // Expectation for the negedge of cycle (now + dc).
  task automatic want(input int unsigned dc, input logic f, input logic [2:0] code,
                      input int flash, input int phase, input string name);
    exp_t e;
    e.cyc = cyc + dc; e.f = f; e.code = code;
    e.flash = flash; e.phase = phase; e.name = name;
    q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)",
                   q[i].name, q[i].cyc, cyc);
        end else if (bus.fault !== q[i].f || bus.fault_code !== q[i].code ||
                     (q[i].flash >= 0 && int'(bus.flash_red) != q[i].flash) ||
                     (q[i].phase >= 0 && int'(bus.ns_phase_cnt) != q[i].phase)) begin
          errors++;
          $display("FAIL %s @cyc %0d: got fault=%0b code=%0d flash=%0b phase=%0d, want fault=%0b code=%0d flash=%0d phase=%0d",
                   q[i].name, cyc, bus.fault, bus.fault_code, bus.flash_red,
                   bus.ns_phase_cnt, q[i].f, q[i].code, q[i].flash, q[i].phase);
        end
        q.delete(i);
      end
    end
    if (done) begin
      foreach (q[k]) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never reached", q[k].name, q[k].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    set_lamps(R, R);
    repeat (3) tick();
    want(0, 0, 0, 0, 0, "reset_state");
    rst = 1'b0;
    apply(R, R, 4);

    // Legal NS then EW cycle
    want(1, 0, 0, 0, 0, "phase_before_rg");
    want(2, 0, 0, 0, 1, "phase_after_rg");
    apply(G, R, 10);
    apply(Y, R, 4);
    want(2, 0, 0, 0, 1, "ns_legal_cycle");
    apply(R, R, 4);
    apply(R, G, 10);
    apply(R, Y, 4);
    want(2, 0, 0, 0, 1, "ew_legal_cycle");
    apply(R, R, 4);

    // Exact minimum dwell on both green and yellow
    want(2, 0, 0, 0, 2, "phase_second");
    apply(G, R, 8);
    want(2, 0, 0, 0, 2, "min_green_exact");
    apply(Y, R, 4);
    want(2, 0, 0, 0, 2, "min_yellow_exact");
    apply(R, R, 4);

    // Conflict for one cycle, flash pattern 1,1,0,0,1
    want(1, 0, 0, 0, 2, "conflict_pre");
    want(2, 1, 1, 1, 3, "conflict_set");
    want(3, 1, 1, 1, 3, "flash_b");
    want(4, 1, 1, 0, 3, "flash_c");
    want(5, 1, 1, 0, 3, "flash_d");
    want(6, 1, 1, 1, 3, "flash_e");
    apply(G, Y, 1);
    apply(R, R, 6);

    // Clear with NS green ignored, then accepted with both red
    bus.fault_clr = 1'b1;
    want(2, 1, 1, -1, 3, "clr_ns_green_a");
    want(3, 1, 1, -1, 3, "clr_ns_green_b");
    apply(G, R, 3);
    want(1, 1, 1, -1, 3, "clr_ns_green_c");
    want(2, 0, 0, 0, 3, "clr_accepted");
    apply(R, R, 4);
    want(2, 0, 0, 0, 3, "clr_without_fault");
    apply(R, R, 3);
    bus.fault_clr = 1'b0;
    apply(R, R, 2);

    // Short yellow, later short EW green leaves the code alone
    want(2, 0, 0, 0, 4, "sy_phase");
    apply(G, R, 10);
    apply(Y, R, 2);
    want(1, 0, 0, 0, 4, "sy_pre");
    want(2, 1, 4, 1, 4, "short_yellow");
    apply(R, R, 4);
    apply(R, G, 3);
    apply(R, Y, 4);
    want(2, 1, 4, -1, 4, "code_frozen");
    apply(R, R, 3);
    bus.fault_clr = 1'b1;
    want(2, 0, 0, 0, 4, "sy_clear");
    apply(R, R, 2);
    bus.fault_clr = 1'b0;
    apply(R, R, 2);

    // Green straight to red
    want(2, 0, 0, 0, 5, "gr_phase");
    apply(G, R, 10);
    want(1, 0, 0, 0, 5, "gr_pre");
    want(2, 1, 3, 1, 5, "skip_yellow");
    apply(R, R, 4);
    bus.fault_clr = 1'b1;
    want(2, 0, 0, 0, 5, "gr_clear");
    apply(R, R, 2);
    bus.fault_clr = 1'b0;
    apply(R, R, 2);

    // EW third bad sample in the same cycle as NS G->R: lamp code wins
    want(2, 0, 0, 0, 6, "tie_phase");
    apply(G, R, 8);
    apply(G, OFF, 2);
    want(1, 0, 0, 0, 6, "tie_pre");
    want(2, 1, 2, 1, 6, "lamp_wins_tie");
    apply(R, OFF, 1);
    apply(R, R, 4);
    bus.fault_clr = 1'b1;
    want(2, 0, 0, 0, 6, "tie_clear");
    apply(R, R, 2);
    bus.fault_clr = 1'b0;
    apply(R, R, 2);

    // EW third bad sample one cycle after NS G->R: sequence code stays
    want(2, 0, 0, 0, 7, "seq_phase");
    apply(G, R, 9);
    apply(G, OFF, 1);
    want(1, 0, 0, 0, 7, "seq_pre");
    want(2, 1, 3, 1, 7, "seq_first");
    want(3, 1, 3, 1, 7, "seq_holds");
    apply(R, OFF, 2);
    apply(R, R, 4);
    bus.fault_clr = 1'b1;
    want(2, 0, 0, 0, 7, "seq_clear");
    apply(R, R, 2);
    bus.fault_clr = 1'b0;
    apply(R, R, 2);

    // NS dark for two cycles is tolerated, three is a lamp fault
    want(2, 0, 0, 0, 7, "off2_a");
    want(3, 0, 0, 0, 7, "off2_b");
    want(4, 0, 0, 0, 7, "off2_c");
    want(5, 0, 0, 0, 7, "off2_d");
    apply(OFF, R, 2);
    apply(R, R, 4);
    want(3, 0, 0, 0, 7, "off3_pre");
    want(4, 1, 2, 1, 7, "off3_fault");
    want(5, 1, 2, 1, 7, "off3_flash");
    apply(OFF, R, 3);
    apply(R, R, 5);

    // Async reset mid-flash, checked before any further clock edge
    rst = 1'b1;
    want(0, 0, 0, 0, 0, "async_reset");
    repeat (2) tick();
    rst = 1'b0;
    want(2, 0, 0, 0, 0, "post_reset");
    apply(R, R, 4);
    done = 1'b1;
    repeat (3) tick();
  end

endmodule
